// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin writeback port arbiter with exception capture into rm0/rm1
module rf_wb_arbiter #(
  parameter int NREQ    = 3,
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_dest,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               exc_req,
  input  logic [DW-1:0]      exc_pc,
  input  logic [DW-1:0]      exc_addr,
  output logic               exc_ack,
  output logic               rf_we,
  output logic [AW-1:0]      rf_dest,
  output logic [DW-1:0]      rf_wdata,
  output logic               rm_we,
  output logic [DW-1:0]      rm_pc,
  output logic [DW-1:0]      rm_addr,
  output logic               busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {RUN, EXC, HOLD} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, idx, gnt_idx;
  logic rf_we_q, rf_we_d, rm_we_q, rm_we_d, exc_ack_q, exc_ack_d;
  logic [AW-1:0] rf_dest_q, rf_dest_d, hs_dest;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d, rm_pc_q, rm_pc_d, rm_addr_q, rm_addr_d, hs_data;
  logic hs, wr;
  // Pick the first valid requester after the last winner; the nearest one overwrites farther ones
  always_comb begin
    gnt_idx = rr_ptr_q;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_valid[idx]) gnt_idx = idx;
    end
  end
  assign hs        = state_q == RUN && !exc_req && |req_valid;
  assign req_ready = hs ? NREQ'(1) << gnt_idx : '0;
  assign hs_dest   = req_dest[int'(gnt_idx)*AW +: AW];
  assign hs_data   = req_data[int'(gnt_idx)*DW +: DW];
  assign wr        = hs && !(DROP_R0 && hs_dest == '0);
  // Next-state: writeback path plus the RUN -> EXC -> HOLD exception sequencer
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = hs ? gnt_idx : rr_ptr_q;
    rf_we_d    = wr;
    rf_dest_d  = wr ? hs_dest : rf_dest_q;
    rf_wdata_d = wr ? hs_data : rf_wdata_q;
    rm_we_d    = 1'b0;
    rm_pc_d    = rm_pc_q;
    rm_addr_d  = rm_addr_q;
    exc_ack_d  = exc_ack_q;
    case (state_q)
      RUN: if (exc_req) begin
        state_d   = EXC;
        rm_we_d   = 1'b1;
        rm_pc_d   = exc_pc;
        rm_addr_d = exc_addr;
        exc_ack_d = 1'b1;
      end
      EXC: state_d = HOLD;
      HOLD: if (!exc_req) begin
        state_d   = RUN;
        exc_ack_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end
  // State and registered outputs; reset abandons any in-flight write or capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      rr_ptr_q   <= PW'(NREQ - 1);
      rf_we_q    <= 1'b0;
      rf_dest_q  <= '0;
      rf_wdata_q <= '0;
      rm_we_q    <= 1'b0;
      rm_pc_q    <= '0;
      rm_addr_q  <= '0;
      exc_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_dest_q  <= rf_dest_d;
      rf_wdata_q <= rf_wdata_d;
      rm_we_q    <= rm_we_d;
      rm_pc_q    <= rm_pc_d;
      rm_addr_q  <= rm_addr_d;
      exc_ack_q  <= exc_ack_d;
    end
  end
  assign rf_we    = rf_we_q;
  assign rf_dest  = rf_dest_q;
  assign rf_wdata = rf_wdata_q;
  assign rm_we    = rm_we_q;
  assign rm_pc    = rm_pc_q;
  assign rm_addr  = rm_addr_q;
  assign exc_ack  = exc_ack_q;
  assign busy     = state_q != RUN || rf_we_q || rm_we_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: scoreboard bench for the writeback arbiter and exception sequencer
module tb_rf_wb_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic [2:0] req_valid = '0, req_ready;
  logic [14:0] req_dest = '0;
  logic [95:0] req_data = '0;
  logic exc_req = 1'b0, exc_ack, rf_we, rm_we, busy;
  logic [31:0] exc_pc = '0, exc_addr = '0, rf_wdata, rm_pc, rm_addr;
  logic [4:0] rf_dest;
  typedef struct {logic we; logic [4:0] dest; logic [31:0] data;} wr_t;
  wr_t sb[$];
  int tests = 0, fails = 0;
  int m_ptr = 2, m_state = 0;
  logic [2:0] r;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_data(req_data), .exc_req(exc_req), .exc_pc(exc_pc),
    .exc_addr(exc_addr), .exc_ack(exc_ack), .rf_we(rf_we), .rf_dest(rf_dest),
    .rf_wdata(rf_wdata), .rm_we(rm_we), .rm_pc(rm_pc), .rm_addr(rm_addr), .busy(busy)
  );

  task automatic set_req(input int i, input logic [4:0] d, input logic [31:0] v);
    req_dest[i*5 +: 5]  = d;
    req_data[i*32 +: 32] = v;
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr = 2;
    m_state = 0;
  endtask

  // One clock from a negedge: check grant against the model, push expected write, pop it after the edge
  task automatic step(output logic [2:0] rdy);
    logic [2:0] exp;
    wr_t e;
    int gi;
    #1;
    exp = '0;
    gi = -1;
    if (m_state == 0 && !exc_req)
      for (int k = 1; k <= 3; k++)
        if (gi < 0 && req_valid[(m_ptr + k) % 3]) gi = (m_ptr + k) % 3;
    if (gi >= 0) exp[gi] = 1'b1;
    rdy = req_ready;
    tests++;
    if (req_ready !== exp) begin
      fails++;
      $display("FAIL ready: got %b expected %b", req_ready, exp);
    end
    if (gi >= 0) begin
      e.dest = req_dest[gi*5 +: 5];
      e.data = req_data[gi*32 +: 32];
      e.we = e.dest != 0;
      m_ptr = gi;
    end else begin
      e.we = 1'b0;
      e.dest = '0;
      e.data = '0;
    end
    sb.push_back(e);
    case (m_state)
      0: if (exc_req) m_state = 1;
      1: m_state = 2;
      2: if (!exc_req) m_state = 0;
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests++;
    if (rf_we !== e.we || (e.we && (rf_dest !== e.dest || rf_wdata !== e.data))) begin
      fails++;
      $display("FAIL rf_write: got we=%b dest=%0d data=%h expected we=%b dest=%0d data=%h",
               rf_we, rf_dest, rf_wdata, e.we, e.dest, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2:0] want [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int c = 0; c < 4; c++) begin
      req_valid = 3'($urandom);
      exc_req = 1'($urandom);
      exc_pc = $urandom;
      exc_addr = $urandom;
      req_dest = 15'($urandom);
      req_data = {$urandom, $urandom, $urandom};
      #2;
      tests++;
      if ({rf_we, rf_dest, rf_wdata, rm_we, rm_pc, rm_addr, exc_ack, busy} !== '0) begin
        fails++;
        $display("FAIL reset_outputs: got we=%b dest=%0d data=%h rm_we=%b pc=%h addr=%h ack=%b busy=%b expected all 0",
                 rf_we, rf_dest, rf_wdata, rm_we, rm_pc, rm_addr, exc_ack, busy);
      end
      @(negedge clk);
    end
    req_valid = '0;
    exc_req = 1'b0;
    rst = 1'b1;
    model_reset();
    set_req(0, 5'd1, 32'hA);
    set_req(1, 5'd2, 32'hB);
    set_req(2, 5'd3, 32'hC);
    req_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      step(r);
      tests++;
      if (r !== want[c]) begin
        fails++;
        $display("FAIL reset_order[%0d]: got %b expected %b", c, r, want[c]);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    set_req(0, 5'd7, 32'hDEADBEEF);
    req_valid = 3'b001;
    step(r);
    tests++;
    if (r !== 3'b001 || rf_we !== 1'b1 || rf_dest !== 5'd7 || rf_wdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single: got rdy=%b we=%b dest=%0d data=%h expected 001 1 7 deadbeef", r, rf_we, rf_dest, rf_wdata);
    end
    req_valid = '0;
    step(r);
    tests++;
    if (rf_we !== 1'b0) begin
      fails++;
      $display("FAIL single_idle: got we=%b expected 0", rf_we);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] want;
    for (int c = 0; c < 6; c++) begin
      set_req(1, 5'd10, 32'h100 + c);
      set_req(0, 5'd11, 32'h200 + c);
      req_valid = (c >= 1) ? 3'b011 : 3'b010;
      want = (c % 2 == 0) ? 3'b010 : 3'b001;
      step(r);
      tests++;
      if (r !== want) begin
        fails++;
        $display("FAIL fairness[%0d]: got %b expected %b", c, r, want);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_r0_drop();
    set_req(2, 5'd0, 32'd5);
    req_valid = 3'b100;
    step(r);
    tests++;
    if (r !== 3'b100 || rf_we !== 1'b0) begin
      fails++;
      $display("FAIL r0_drop: got rdy=%b we=%b expected 100 0", r, rf_we);
    end
    req_valid = '0;
  endtask

  task automatic test_exception();
    set_req(0, 5'd3, 32'h33);
    set_req(1, 5'd4, 32'h44);
    req_valid = 3'b011;
    exc_req = 1'b1;
    exc_pc = 32'h100;
    exc_addr = 32'h2000;
    step(r);
    exc_pc = 32'hFFF;
    exc_addr = 32'hEEE;
    tests++;
    if (r !== 3'b000 || rm_we !== 1'b1 || rm_pc !== 32'h100 || rm_addr !== 32'h2000 || exc_ack !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL exc_capture: got rdy=%b rm_we=%b pc=%h addr=%h ack=%b busy=%b expected 000 1 100 2000 1 1",
               r, rm_we, rm_pc, rm_addr, exc_ack, busy);
    end
    step(r);
    tests++;
    if (rm_we !== 1'b0 || exc_ack !== 1'b1 || rm_pc !== 32'h100) begin
      fails++;
      $display("FAIL exc_strobe: got rm_we=%b ack=%b pc=%h expected 0 1 100", rm_we, exc_ack, rm_pc);
    end
    step(r);
    tests++;
    if (exc_ack !== 1'b1 || rm_we !== 1'b0) begin
      fails++;
      $display("FAIL exc_hold: got ack=%b rm_we=%b expected 1 0", exc_ack, rm_we);
    end
    exc_req = 1'b0;
    step(r);
    tests++;
    if (exc_ack !== 1'b0 || r !== 3'b000) begin
      fails++;
      $display("FAIL exc_release: got ack=%b rdy=%b expected 0 000", exc_ack, r);
    end
    step(r);
    tests++;
    if (r !== 3'b001) begin
      fails++;
      $display("FAIL exc_resume: got %b expected 001", r);
    end
    req_valid = '0;
  endtask

  task automatic test_async_reset();
    set_req(1, 5'd9, 32'h55);
    req_valid = 3'b010;
    step(r);
    req_valid = '0;
    exc_req = 1'b1;
    exc_pc = 32'h300;
    exc_addr = 32'h4000;
    step(r);
    step(r);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({rf_we, rf_dest, rf_wdata, rm_we, rm_pc, rm_addr, exc_ack, busy} !== '0) begin
      fails++;
      $display("FAIL async_reset: got we=%b dest=%0d data=%h rm_we=%b pc=%h addr=%h ack=%b busy=%b expected all 0",
               rf_we, rf_dest, rf_wdata, rm_we, rm_pc, rm_addr, exc_ack, busy);
    end
    exc_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    set_req(0, 5'd12, 32'h77);
    set_req(1, 5'd13, 32'h88);
    set_req(2, 5'd14, 32'h99);
    req_valid = 3'b111;
    step(r);
    tests++;
    if (r !== 3'b001) begin
      fails++;
      $display("FAIL async_first_grant: got %b expected 001", r);
    end
    req_valid = '0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_r0_drop();
    test_exception();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
